// File: rtl/disp_share_pkg.sv
// rtl/disp_share_pkg.sv - shared types and helpers for the display sharer
package disp_share_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHOW = 2'd1,
    GAP  = 2'd2,
    HOLD = 2'd3
  } disp_state_e;

  // Active-low all-segments-off code understood by the hex-pair decoder.
  localparam logic [13:0] SEG_OFF = 14'h3FFF;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/disp_share_rr_arb.sv
// rtl/disp_share_rr_arb.sv - combinational round-robin arbiter, search starts at ptr
module rr_arb #(
  parameter int N  = 3,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  always_comb begin
    int          j;
    logic [IW-1:0] jj;
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    j       = 0;
    jj      = '0;
    for (int k = 0; k < N; k++) begin
      // ptr is always below N, so one subtraction performs the wrap.
      j = int'(ptr_i) + k;
      if (j >= N) j = j - N;
      jj = IW'(j);
      if (!any_o && req_i[jj]) begin
        any_o       = 1'b1;
        grant_o[jj] = 1'b1;
        idx_o       = jj;
      end
    end
  end

endmodule

// File: rtl/disp_share_ctrl.sv
// rtl/disp_share_ctrl.sv - time-shares one hex display pair among N_REQ requesters
module disp_share_ctrl
  import disp_share_pkg::*;
#(
  parameter int N_REQ   = 3,
  parameter int DWELL   = 50000000,
  parameter int GAP_CYC = 5000000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req,
  input  logic [8*N_REQ-1:0] data,
  output logic [N_REQ-1:0]   ack,
  output logic [7:0]         disp_byte,
  output logic               disp_blank,
  output logic [2:0]         disp_src
);

  localparam int IW   = idx_w(N_REQ);
  localparam int CMAX = (DWELL > GAP_CYC) ? DWELL : GAP_CYC;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [CW-1:0] DWELL_LD = CW'(DWELL - 1);
  localparam logic [CW-1:0] GAP_LD   = CW'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

  disp_state_e      state_q, state_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic [IW-1:0]    src_q, src_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [N_REQ-1:0] ack_q, ack_d;
  logic [7:0]       byte_q, byte_d;
  logic             blank_q, blank_d;

  logic [N_REQ-1:0] win_gnt;
  logic [IW-1:0]    win_idx;
  logic             win_any;
  logic             grant_now, gap_now;
  logic [7:0]       bytes [N_REQ];

  for (genvar i = 0; i < N_REQ; i++) begin : g_bytes
    assign bytes[i] = data[8*i +: 8];
  end

  rr_arb #(.N(N_REQ), .IW(IW)) u_arb (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .grant_o (win_gnt),
    .idx_o   (win_idx),
    .any_o   (win_any)
  );

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    src_d     = src_q;
    cnt_d     = cnt_q;
    ack_d     = '0;
    byte_d    = byte_q;
    blank_d   = blank_q;
    grant_now = 1'b0;
    gap_now   = 1'b0;

    case (state_q)
      IDLE: begin
        blank_d = 1'b1;
        if (win_any) grant_now = 1'b1;
      end
      SHOW: begin
        if (req[src_q]) byte_d = bytes[src_q];
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (!win_any) begin
          state_d = HOLD;
          blank_d = 1'b0;
        end else if (win_idx == src_q || GAP_CYC == 0) begin
          grant_now = 1'b1;
        end else begin
          gap_now = 1'b1;
        end
      end
      GAP: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (win_any) begin
          grant_now = 1'b1;
        end else begin
          state_d = HOLD;
          blank_d = 1'b0;
        end
      end
      HOLD: begin
        blank_d = 1'b0;
        if (win_any) begin
          if (win_idx == src_q || GAP_CYC == 0) grant_now = 1'b1;
          else gap_now = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // The gap keeps the old byte and source; only the blank flag changes.
    if (gap_now) begin
      state_d = GAP;
      blank_d = 1'b1;
      cnt_d   = GAP_LD;
    end
    if (grant_now) begin
      state_d = SHOW;
      byte_d  = bytes[win_idx];
      src_d   = win_idx;
      blank_d = 1'b0;
      ack_d   = win_gnt;
      cnt_d   = DWELL_LD;
      ptr_d   = (int'(win_idx) == N_REQ - 1) ? '0 : win_idx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      src_q   <= '0;
      cnt_q   <= '0;
      ack_q   <= '0;
      byte_q  <= 8'h00;
      blank_q <= 1'b1;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      src_q   <= src_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      byte_q  <= byte_d;
      blank_q <= blank_d;
    end
  end

  assign ack        = ack_q;
  assign disp_byte  = byte_q;
  assign disp_blank = blank_q;
  assign disp_src   = 3'(src_q);

endmodule

// File: tb/tb_disp_share_ctrl.sv
// tb/tb_disp_share_ctrl.sv - self-checking bench for disp_share_ctrl
module tb_disp_share_ctrl;

  localparam int NR = 3;
  localparam int DW = 4;
  localparam int GP = 2;
  localparam int P_IDLE = 0, P_SHOW = 1, P_GAP = 2, P_HOLD = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  req = 3'b000;
  logic [23:0] data = 24'h0;
  logic [2:0]  ack;
  logic [7:0]  disp_byte;
  logic        disp_blank;
  logic [2:0]  disp_src;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: current owner, phase and cycles left in that phase.
  int         m_ph = P_IDLE, m_left = 0, m_ptr = 0, m_src = 0;
  logic [2:0] m_ack = 3'b000;
  logic [7:0] m_byte = 8'h00;
  logic       m_blank = 1'b1;
  int         n_ph, n_left, n_ptr, n_src;
  logic [2:0] n_ack;
  logic [7:0] n_byte;
  logic       n_blank;

  disp_share_ctrl #(.N_REQ(NR), .DWELL(DW), .GAP_CYC(GP)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .data       (data),
    .ack        (ack),
    .disp_byte  (disp_byte),
    .disp_blank (disp_blank),
    .disp_src   (disp_src)
  );

  always #5 clk = ~clk;

  function automatic int pick(input logic [2:0] r, input int p);
    for (int k = 0; k < NR; k++) begin
      if (r[(p + k) % NR]) return (p + k) % NR;
    end
    return -1;
  endfunction

  task automatic model_step();
    int w;
    bit do_grant, do_gap;
    n_ph = m_ph; n_left = m_left; n_ptr = m_ptr; n_src = m_src;
    n_ack = 3'b000; n_byte = m_byte; n_blank = m_blank;
    do_grant = 0; do_gap = 0;
    if (!rst_n) begin
      n_ph = P_IDLE; n_left = 0; n_ptr = 0; n_src = 0;
      n_byte = 8'h00; n_blank = 1'b1;
    end else begin
      w = pick(req, m_ptr);
      case (m_ph)
        P_IDLE: if (w >= 0) do_grant = 1;
        P_SHOW: begin
          if (req[m_src]) n_byte = data[8*m_src +: 8];
          if (m_left > 0) n_left = m_left - 1;
          else if (w < 0) begin n_ph = P_HOLD; n_blank = 1'b0; end
          else if (w == m_src) do_grant = 1;
          else do_gap = 1;
        end
        P_GAP: begin
          if (m_left > 0) n_left = m_left - 1;
          else if (w >= 0) do_grant = 1;
          else begin n_ph = P_HOLD; n_blank = 1'b0; end
        end
        default: if (w >= 0) begin
          if (w == m_src) do_grant = 1;
          else do_gap = 1;
        end
      endcase
      if (do_gap) begin n_ph = P_GAP; n_left = GP - 1; n_blank = 1'b1; end
      if (do_grant) begin
        n_ph = P_SHOW; n_left = DW - 1; n_src = w; n_blank = 1'b0;
        n_byte = data[8*w +: 8]; n_ack = 3'(1 << w); n_ptr = (w + 1) % NR;
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    m_ph = n_ph; m_left = n_left; m_ptr = n_ptr; m_src = n_src;
    m_ack = n_ack; m_byte = n_byte; m_blank = n_blank;
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = 3'b111; data = 24'h332211;
    for (int c = 0; c < 2; c++) begin
      tick();
      n_vec++;
      if ({ack, disp_byte, disp_blank, disp_src} !== {3'b000, 8'h00, 1'b1, 3'd0}) begin
        n_err++;
        $display("FAIL reset_state cyc=%0d got ack=%b byte=%h blank=%b src=%0d want 000/00/1/0",
                 c, ack, disp_byte, disp_blank, disp_src);
      end
    end
    rst_n = 1'b1;
    tick();
    n_vec++;
    if ({ack, disp_byte, disp_blank, disp_src} !== {3'b001, 8'h11, 1'b0, 3'd0}) begin
      n_err++;
      $display("FAIL reset_release got ack=%b byte=%h blank=%b src=%0d want 001/11/0/0",
               ack, disp_byte, disp_blank, disp_src);
    end
  endtask

  task automatic test_single();
    logic [2:0] e_ack;
    req = 3'b000; do_reset();
    req = 3'b010; data = 24'h00A500;
    for (int c = 1; c <= 9; c++) begin
      tick();
      e_ack = (c == 1 || c == 5 || c == 9) ? 3'b010 : 3'b000;
      n_vec++;
      if ({ack, disp_byte, disp_blank, disp_src} !== {e_ack, 8'hA5, 1'b0, 3'd1}) begin
        n_err++;
        $display("FAIL single cyc=%0d got ack=%b byte=%h blank=%b src=%0d want %b/a5/0/1",
                 c, ack, disp_byte, disp_blank, disp_src, e_ack);
      end
    end
  endtask

  task automatic test_contention();
    int seg, pos;
    logic [2:0] e_ack;
    logic [7:0] e_byte;
    logic       e_blank;
    req = 3'b000; do_reset();
    req = 3'b111; data = 24'h332211;
    for (int k = 0; k <= 18; k++) begin
      tick();
      seg = (k / 6) % 3; pos = k % 6;
      e_byte  = 8'(8'h11 * (seg + 1));
      e_blank = (pos >= 4);
      e_ack   = (pos == 0) ? 3'(1 << seg) : 3'b000;
      n_vec++;
      if ({ack, disp_byte, disp_blank, disp_src} !== {e_ack, e_byte, e_blank, 3'(seg)}) begin
        n_err++;
        $display("FAIL contention k=%0d got ack=%b byte=%h blank=%b src=%0d want %b/%h/%b/%0d",
                 k, ack, disp_byte, disp_blank, disp_src, e_ack, e_byte, e_blank, seg);
      end
    end
  endtask

  task automatic test_live_hold();
    logic [7:0] e_byte [1:6];
    e_byte[1] = 8'h10; e_byte[2] = 8'h11; e_byte[3] = 8'h11;
    e_byte[4] = 8'h11; e_byte[5] = 8'h11; e_byte[6] = 8'h11;
    req = 3'b000; do_reset();
    req = 3'b001; data = 24'h000010;
    for (int c = 1; c <= 6; c++) begin
      tick();
      n_vec++;
      if ({ack, disp_byte, disp_blank, disp_src} !== {(c == 1) ? 3'b001 : 3'b000, e_byte[c], 1'b0, 3'd0}) begin
        n_err++;
        $display("FAIL live_hold cyc=%0d got ack=%b byte=%h blank=%b src=%0d want byte %h blank 0",
                 c, ack, disp_byte, disp_blank, disp_src, e_byte[c]);
      end
      if (c == 1) data = 24'h000011;
      if (c == 2) begin req = 3'b000; data = 24'h000099; end
    end
    // Same source from HOLD: immediate grant, no blank.
    req = 3'b001; data = 24'h00007E;
    tick();
    n_vec++;
    if ({ack, disp_byte, disp_blank, disp_src} !== {3'b001, 8'h7E, 1'b0, 3'd0}) begin
      n_err++;
      $display("FAIL hold_same got ack=%b byte=%h blank=%b src=%0d want 001/7e/0/0",
               ack, disp_byte, disp_blank, disp_src);
    end
    req = 3'b000;
    for (int c = 0; c < 5; c++) tick();
    // Different source from HOLD: two blank cycles, then grant.
    req = 3'b100; data = 24'hC3007E;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_vec++;
      if (c < 2 && {ack, disp_byte, disp_blank, disp_src} !== {3'b000, 8'h7E, 1'b1, 3'd0}) begin
        n_err++;
        $display("FAIL hold_other_gap cyc=%0d got ack=%b byte=%h blank=%b src=%0d want 000/7e/1/0",
                 c, ack, disp_byte, disp_blank, disp_src);
      end
      if (c == 2 && {ack, disp_byte, disp_blank, disp_src} !== {3'b100, 8'hC3, 1'b0, 3'd2}) begin
        n_err++;
        $display("FAIL hold_other_grant got ack=%b byte=%h blank=%b src=%0d want 100/c3/0/2",
                 ack, disp_byte, disp_blank, disp_src);
      end
    end
  endtask

  task automatic test_reset_mid_show();
    req = 3'b000; do_reset();
    req = 3'b111; data = 24'h665544;
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    n_vec++;
    if ({ack, disp_byte, disp_blank, disp_src} !== {3'b000, 8'h00, 1'b1, 3'd0}) begin
      n_err++;
      $display("FAIL reset_mid_show got ack=%b byte=%h blank=%b src=%0d want 000/00/1/0",
               ack, disp_byte, disp_blank, disp_src);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    req = 3'b000; do_reset();
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 3) == 0) req = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 2) == 0) data = 24'($urandom);
      rst_n = ($urandom_range(0, 79) != 0);
      tick();
      n_vec++;
      if ({ack, disp_byte, disp_blank, disp_src} !== {m_ack, m_byte, m_blank, 3'(m_src)}) begin
        n_err++;
        $display("FAIL random cyc=%0d got ack=%b byte=%h blank=%b src=%0d want %b/%h/%b/%0d",
                 c, ack, disp_byte, disp_blank, disp_src, m_ack, m_byte, m_blank, m_src);
      end
    end
    rst_n = 1'b1;
  endtask

  initial begin
    #2;
    test_reset();
    test_single();
    test_contention();
    test_live_hold();
    test_reset_mid_show();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/disp_share_ctrl.md
Name: disp_share_ctrl

Overview:
Time-shares the board's single two-digit hex seven-segment display pair between several requesters, such as a counter, an ALU result and a keyboard scancode.
- Round-robin arbitration with a minimum dwell time per owner.
- Optional blank gap between different owners.
- Drives an 8-bit byte plus a blank flag into the downstream hex-pair segment decoder; the decoder forces all segments off when blank is set.

Parameters:
N_REQ, 3, number of requesters (2..8)
DWELL, 50000000, display cycles per grant (>=1)
GAP_CYC, 5000000, blank cycles on owner change (0 = no gap)

Ports:
clk  in  1  system clock
rst_n  in  1  reset; one clock, reset is synchronous and active-low
req  in  N_REQ  per-requester display request, level
data  in  8*N_REQ  requester i byte at data[8*i+7:8*i]
ack  out  N_REQ  one-cycle pulse: data of requester i latched, new dwell started
disp_byte  out  8  byte to segment decoder
disp_blank  out  1  1 = segments off
disp_src  out  3  index of current/last owner

Behaviour:
- Reset (rst_n low at posedge):
  - state=IDLE, ack=0, disp_byte=0, disp_blank=1, disp_src=0.
  - rr pointer=0, counters=0.
  - Reset mid-operation aborts any dwell or gap immediately.
- Arbitration (combinational, used in IDLE, HOLD and at dwell end):
  - First requester with req=1 searching from ptr upward, wrapping mod N_REQ.
  - ptr = last granted index + 1 (mod N_REQ).
- Grant (decision in cycle t, registered at edge t+1):
  - disp_byte=data[g], disp_src=g, disp_blank=0.
  - ack[g]=1 for cycle t+1 only; dwell counter=DWELL-1.
  - Latency from req to ack and display is 1 cycle.
- States:
  - IDLE: blank. Any req -> grant -> SHOW (no gap).
  - SHOW: counter decrements each cycle.
    - While req[owner]=1, disp_byte tracks data[owner] with 1-cycle latency; the dwell is not restarted.
    - If req[owner] drops, the last value is frozen and the dwell continues.
  - At counter==0, arbitrate:
    - winner==owner (no other req): re-grant, stay SHOW, new ack pulse, no blank.
    - winner!=owner and GAP_CYC>0: GAP with gap counter=GAP_CYC-1.
    - winner!=owner and GAP_CYC==0: grant directly.
    - no req: HOLD.
  - GAP: disp_blank=1, disp_byte and disp_src unchanged.
    - At gap counter==0, re-arbitrate using req of that cycle.
    - Winner -> grant -> SHOW.
    - None -> HOLD (value still held; blank cleared).
  - HOLD: show last value indefinitely, blank=0. On any req:
    - same src: grant directly.
    - different src: GAP if GAP_CYC>0, else direct grant.
- ack is never asserted for more than one bit or for more than one consecutive cycle per grant.
- data of non-owners is ignored.
- Counter width $clog2(max(DWELL,GAP_CYC)+1), unsigned. No wrap: each counter stops at 0.

Decomposition:
- Package disp_share_pkg:
  - state enum {IDLE, SHOW, GAP, HOLD}.
  - SEG_OFF=14'h3FFF (active-low all-off code used by the decoder).
  - Helper function idx_w(N_REQ).
- Sub-module rr_arb:
  - Inputs req and ptr; outputs one-hot grant, index and any_req.
  - Purely combinational, reusable by other board resource sharers.

Test Plan:
All scenarios use N_REQ=3, DWELL=4, GAP_CYC=2.
- Reset: rst_n=0 for 2 cycles with req=3'b111 -> ack=0, disp_blank=1, disp_byte=0, disp_src=0 throughout. First cycle after release: decision; ack[0]=1 the next cycle.
- Single requester: req=3'b010, data[15:8]=8'hA5 at t -> ack=3'b010 at t+1; disp_byte=A5, blank=0 for t+1..t+4; ack=3'b010 again at t+5; blank never asserted.
- Full contention: req=3'b111, bytes 11/22/33 -> display sequence 11 x4, blank x2, 22 x4, blank x2, 33 x4, blank x2, 11. ack pulses 001, 010, 100, 001.
- Live update and drop: owner 0 shows 10. Mid-dwell data changes to 11 -> disp_byte=11 one cycle later, dwell length unchanged. req[0] drops and data becomes 99 -> 11 held through dwell end; state HOLD, blank=0.
- HOLD re-entry: from HOLD with src 0:
  - req[0]=1, data 7E -> ack[0] and 7E next cycle, no blank.
  - req[2]=1 instead -> 2 blank cycles, then ack[2].
- Reset mid-SHOW: rst_n low on dwell cycle 2 -> next cycle IDLE outputs; any pending ack suppressed.
